// File: rtl/clock_ctrl_pkg.sv
// Shared types and defaults for the clock-switch control slice.
// FSM state encoding, wait defaults and response error code meaning.
package clock_ctrl_pkg;

  localparam int CNT_W_DEF        = 8;
  localparam int DEFAULT_WAIT_DEF = 8;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_CHECK,
    ST_OFF,
    ST_SETTLE
  } state_t;

  // resp_err meaning when resp_valid is high
  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/clock_ctrl_down_counter.sv
// Loadable down-counter shared by the STARTUP, OFF and SETTLE waits.
// Ports: clock, reset, load_i/load_val_i (reload), dec_i (count), zero_o.
module clock_ctrl_down_counter #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // High on the last counted cycle: the next decrement lands on zero,
  // so the owner can act on that same edge.
  assign zero_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/clock_switch_sequencer.sv
// Glitch-free clock switch sequencer: gate off, hold, reselect, settle, gate on.
// Ports: req_* handshake in, mux_sel/gate_en to clock cells, resp_* pulse, busy.
module clock_switch_sequencer
  import clock_ctrl_pkg::*;
#(
  parameter int NUM_CLOCKS   = 4,
  parameter int SEL_W        = $clog2(NUM_CLOCKS),
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_WAIT = DEFAULT_WAIT_DEF,
  parameter int RESET_SEL    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic [CNT_W-1:0] cfg_wait,
  output logic [SEL_W-1:0] mux_sel,
  output logic             gate_en,
  output logic             resp_valid,
  output logic             resp_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEFAULT_WAIT);

  state_t           state_q;
  logic [SEL_W-1:0] mux_sel_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] wait_q;
  logic             gate_en_q;
  logic             ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             busy_q;

  logic             accept;
  logic             bad_sel;
  logic             same_sel;
  logic [CNT_W-1:0] w_eff;
  logic             cnt_zero;
  logic             cnt_load_d;
  logic             cnt_dec_d;
  logic [CNT_W-1:0] cnt_val_d;

  assign accept   = req_valid && ready_q;
  assign bad_sel  = {1'b0, req_sel} >= (SEL_W+1)'(NUM_CLOCKS);
  assign same_sel = (req_sel == mux_sel_q);
  assign w_eff    = (cfg_wait == '0) ? DEF_W : cfg_wait;

  always_comb begin
    cnt_load_d = 1'b0;
    cnt_dec_d  = 1'b0;
    cnt_val_d  = wait_q;
    case (state_q)
      ST_STARTUP: cnt_dec_d = 1'b1;
      ST_IDLE: begin
        if (accept && !bad_sel && !same_sel) begin
          cnt_load_d = 1'b1;
          cnt_val_d  = w_eff;
        end
      end
      ST_OFF: begin
        // reload W for the settle phase on the reselect edge
        if (cnt_zero) cnt_load_d = 1'b1;
        else          cnt_dec_d  = 1'b1;
      end
      ST_SETTLE: cnt_dec_d = 1'b1;
      default: ;
    endcase
  end

  clock_ctrl_down_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (DEF_W)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load_d),
    .load_val_i (cnt_val_d),
    .dec_i      (cnt_dec_d),
    .zero_o     (cnt_zero)
  );

  // The range/same-select decision is made on the accept edge so its
  // outcome is visible one cycle after the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_STARTUP;
      mux_sel_q    <= SEL_W'(RESET_SEL);
      sel_q        <= '0;
      wait_q       <= DEF_W;
      gate_en_q    <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= RESP_OK;
      busy_q       <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= RESP_OK;
      case (state_q)
        ST_STARTUP: begin
          if (cnt_zero) begin
            state_q   <= ST_IDLE;
            gate_en_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            sel_q   <= req_sel;
            wait_q  <= w_eff;
            if (bad_sel) begin
              state_q      <= ST_CHECK;
              resp_valid_q <= 1'b1;
              resp_err_q   <= RESP_ERR;
            end else if (same_sel) begin
              state_q      <= ST_CHECK;
              resp_valid_q <= 1'b1;
            end else begin
              state_q   <= ST_OFF;
              gate_en_q <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_OFF: begin
          if (cnt_zero) begin
            state_q   <= ST_SETTLE;
            mux_sel_q <= sel_q;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q      <= ST_IDLE;
            gate_en_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mux_sel    = mux_sel_q;
  assign gate_en    = gate_en_q;
  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed bench for clock_switch_sequencer (4-clock and 3-clock builds).
// Cycle 0 is the first cycle with reset low; sampling is #1 after posedge.
module tb_clock_switch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic [7:0] cfg_wait;
  logic [1:0] mux_sel;
  logic       gate_en;
  logic       resp_valid;
  logic       resp_err;
  logic       busy;

  logic       req_valid2;
  logic       req_ready2;
  logic [1:0] req_sel2;
  logic [7:0] cfg_wait2;
  logic [1:0] mux_sel2;
  logic       gate_en2;
  logic       resp_valid2;
  logic       resp_err2;
  logic       busy2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [1:0] mon_prev = 2'd0;

  always #5 clk = ~clk;

  clock_switch_sequencer #(
    .NUM_CLOCKS (4)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .cfg_wait   (cfg_wait),
    .mux_sel    (mux_sel),
    .gate_en    (gate_en),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  clock_switch_sequencer #(
    .NUM_CLOCKS (3)
  ) dut3 (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (req_valid2),
    .req_ready  (req_ready2),
    .req_sel    (req_sel2),
    .cfg_wait   (cfg_wait2),
    .mux_sel    (mux_sel2),
    .gate_en    (gate_en2),
    .resp_valid (resp_valid2),
    .resp_err   (resp_err2),
    .busy       (busy2)
  );

  // mux_sel must never move while the gate is open
  always @(negedge clk) begin
    if (mux_sel !== mon_prev) begin
      checks++;
      if (gate_en !== 1'b0) begin
        errors++;
        $display("FAIL mon_gate: mux %0d->%0d gate_en=%b want 0",
                 mon_prev, mux_sel, gate_en);
      end
    end
    mon_prev = mux_sel;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
    checks++;
    if ({mux_sel, gate_en, req_ready, resp_valid, resp_err, busy}
        !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_vals: got %b want 00_0_0_0_0_1",
               {mux_sel, gate_en, req_ready, resp_valid, resp_err, busy});
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_resp: cyc %0d resp_valid=%b want 0",
                 cyc, resp_valid);
      end
      checks++;
      if (c < 8) begin
        if ({gate_en, req_ready, busy} !== 3'b001) begin
          errors++;
          $display("FAIL start_wait: cyc %0d got %b want 001",
                   cyc, {gate_en, req_ready, busy});
        end
      end else begin
        if ({gate_en, req_ready, busy, mux_sel} !== 5'b11000) begin
          errors++;
          $display("FAIL start_done: cyc %0d got %b want 11000",
                   cyc, {gate_en, req_ready, busy, mux_sel});
        end
      end
    end
    checks++;
    if ({gate_en2, req_ready2} !== 2'b11) begin
      errors++;
      $display("FAIL start_dut3: got %b want 11", {gate_en2, req_ready2});
    end
  endtask

  task automatic test_switch;
    tick();
    tick();
    req_valid = 1'b1;
    req_sel   = 2'd2;
    cfg_wait  = 8'd4;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({gate_en, req_ready, busy, mux_sel, resp_valid}
        !== {1'b0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL sw_a1: cyc %0d got %b want 0010_00",
               cyc, {gate_en, req_ready, busy, mux_sel, resp_valid});
    end
    for (int c = 12; c <= 18; c++) begin
      tick();
      if (c == 12) begin
        req_valid = 1'b1;
        req_sel   = 2'd3;
      end
      if (c == 13) req_valid = 1'b0;
      checks++;
      if ({gate_en, req_ready, resp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL sw_hold: cyc %0d got %b want 000",
                 cyc, {gate_en, req_ready, resp_valid});
      end
      checks++;
      if (mux_sel !== ((c >= 15) ? 2'd2 : 2'd0)) begin
        errors++;
        $display("FAIL sw_mux: cyc %0d mux_sel=%0d want %0d",
                 cyc, mux_sel, (c >= 15) ? 2 : 0);
      end
    end
    tick();
    checks++;
    if ({gate_en, resp_valid, resp_err, req_ready, busy, mux_sel}
        !== {5'b11010, 2'd2}) begin
      errors++;
      $display("FAIL sw_done: cyc %0d got %b want 1101010",
               cyc, {gate_en, resp_valid, resp_err, req_ready, busy, mux_sel});
    end
    tick();
    checks++;
    if ({resp_valid, mux_sel, gate_en} !== 4'b0101) begin
      errors++;
      $display("FAIL sw_after: got %b want 0101",
               {resp_valid, mux_sel, gate_en});
    end
  endtask

  task automatic test_same_sel;
    req_valid = 1'b1;
    req_sel   = 2'd2;
    cfg_wait  = 8'd5;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_err, gate_en, mux_sel, req_ready, busy}
        !== 7'b1011001) begin
      errors++;
      $display("FAIL same_a1: got %b want 1011001",
               {resp_valid, resp_err, gate_en, mux_sel, req_ready, busy});
    end
    tick();
    checks++;
    if ({resp_valid, req_ready, busy, gate_en} !== 4'b0101) begin
      errors++;
      $display("FAIL same_a2: got %b want 0101",
               {resp_valid, req_ready, busy, gate_en});
    end
  endtask

  task automatic test_range;
    req_valid2 = 1'b1;
    req_sel2   = 2'd3;
    cfg_wait2  = 8'd0;
    tick();
    req_valid2 = 1'b0;
    checks++;
    if ({resp_valid2, resp_err2, gate_en2, mux_sel2, req_ready2}
        !== 6'b111000) begin
      errors++;
      $display("FAIL range_a1: got %b want 111000",
               {resp_valid2, resp_err2, gate_en2, mux_sel2, req_ready2});
    end
    tick();
    checks++;
    if ({resp_valid2, req_ready2, gate_en2, mux_sel2} !== 5'b01100) begin
      errors++;
      $display("FAIL range_a2: got %b want 01100",
               {resp_valid2, req_ready2, gate_en2, mux_sel2});
    end
  endtask

  task automatic test_min_wait;
    req_valid = 1'b1;
    req_sel   = 2'd1;
    cfg_wait  = 8'd1;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({gate_en, mux_sel, resp_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL w1_a1: got %b want 0100",
               {gate_en, mux_sel, resp_valid});
    end
    tick();
    checks++;
    if ({gate_en, mux_sel, resp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL w1_a2: got %b want 0010",
               {gate_en, mux_sel, resp_valid});
    end
    tick();
    checks++;
    if ({gate_en, resp_valid, resp_err, mux_sel, req_ready} !== 6'b110011) begin
      errors++;
      $display("FAIL w1_a3: got %b want 110011",
               {gate_en, resp_valid, resp_err, mux_sel, req_ready});
    end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1;
    req_sel   = 2'd3;
    cfg_wait  = 8'd4;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if ({mux_sel, gate_en} !== 3'b110) begin
      errors++;
      $display("FAIL mid_pre: got %b want 110", {mux_sel, gate_en});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({mux_sel, gate_en, busy, req_ready, resp_valid} !== 6'b000100) begin
      errors++;
      $display("FAIL mid_rst: got %b want 000100",
               {mux_sel, gate_en, busy, req_ready, resp_valid});
    end
    reset = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_resp: cyc %0d resp_valid=%b want 0",
                 cyc, resp_valid);
      end
      checks++;
      if (gate_en !== (c == 8)) begin
        errors++;
        $display("FAIL mid_start: cyc %0d gate_en=%b want %b",
                 cyc, gate_en, (c == 8));
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc[3];
    int n;
    bit flip;
    bit got;
    n = 0;
    req_valid = 1'b1;
    req_sel   = 2'd1;
    cfg_wait  = 8'd0;
    for (int c = 0; c < 80 && n < 3; c++) begin
      flip = 1'b0;
      if (req_ready === 1'b1) begin
        acc[n] = cyc;
        if (n > 0) begin
          checks++;
          if ({resp_valid, resp_err} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_resp: cyc %0d got %b want 10",
                     cyc, {resp_valid, resp_err});
          end
          checks++;
          if (acc[n] - acc[n-1] !== 17) begin
            errors++;
            $display("FAIL b2b_gap: gap %0d want 17", acc[n] - acc[n-1]);
          end
        end
        n++;
        flip = 1'b1;
      end
      tick();
      if (flip) req_sel = (req_sel == 2'd1) ? 2'd3 : 2'd1;
    end
    req_valid = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_count: accepts %0d want 3", n);
    end else begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        if (resp_valid === 1'b1) got = 1'b1;
        else tick();
      end
      checks++;
      if (!got || (cyc - acc[2]) !== 17) begin
        errors++;
        $display("FAIL b2b_last: resp after %0d cycles want 17",
                 cyc - acc[2]);
      end
      checks++;
      if ({mux_sel, gate_en} !== 3'b011) begin
        errors++;
        $display("FAIL b2b_mux: got %b want 011", {mux_sel, gate_en});
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_sel    = 2'd0;
    cfg_wait   = 8'd0;
    req_valid2 = 1'b0;
    req_sel2   = 2'd0;
    cfg_wait2  = 8'd0;
    test_reset();
    test_switch();
    test_same_sel();
    test_range();
    test_min_wait();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
